matrix_text: RTL and testbench

Inverse of the text/key matrix loader in the 4-bit-cell cipher datapath. Accepts a finished 4x4 nibble state matrix (e.g. ciphertext after the last round) through a valid/ready handshake. It flattens the matrix into the 16-nibble text vector using the same cell ordering the loader consumes. It then streams the 16 nibbles out one per transfer, with backpressure, to the output/UART side of the design.

---
 rtl/cipher_pkg.sv | 29 ++
 rtl/matrix_text_if.sv | 33 +++
 rtl/matrix_text.sv | 106 ++++++++++
 tb/tb_matrix_text.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// ---------------------------------------------------------------------------
// cipher_pkg
// Shared definitions for the 4-bit-cell cipher datapath: cell width, text
// length, nibble/matrix/text types, the matrix<->text cell ordering used by
// both the matrix loader and matrix_text, and the matrix_text FSM states.
// No ports (package).
// ---------------------------------------------------------------------------
package cipher_pkg;

  localparam int NIBBLE_W = 4;
  localparam int CELLS    = 16;

  typedef logic [NIBBLE_W-1:0]     nibble_t;
  typedef nibble_t [0:3][0:3]      state_mat_t;
  typedef nibble_t [CELLS-1:0]     text_vec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } mt_state_e;

  // Text position of matrix cell [i][j]; cell [0][0] is the most significant
  // nibble of the text vector. The loader uses this same function, so both
  // ends of the datapath agree on ordering by construction.
  function automatic int cell_idx(input int i, input int j);
    return CELLS - 1 - (4 * i + j);
  endfunction

endpackage

// File: rtl/matrix_text_if.sv
// ---------------------------------------------------------------------------
// matrix_text_if
// Bundles the matrix input handshake and the nibble output stream of
// matrix_text.
//   st_matrix/in_valid/in_ready : 4x4 state matrix handshake
//   text                        : registered flattened text vector
//   nib_out/nib_valid/nib_ready : nibble stream with backpressure
//   text_done                   : one-cycle pulse after the last nibble
// Modports: slave = matrix_text side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface matrix_text_if;
  import cipher_pkg::*;

  state_mat_t st_matrix;
  logic       in_valid;
  logic       in_ready;
  text_vec_t  text;
  nibble_t    nib_out;
  logic       nib_valid;
  logic       nib_ready;
  logic       text_done;

  modport slave (
    input  st_matrix, in_valid, nib_ready,
    output in_ready, text, nib_out, nib_valid, text_done
  );

  modport master (
    output st_matrix, in_valid, nib_ready,
    input  in_ready, text, nib_out, nib_valid, text_done
  );

endinterface

// File: rtl/matrix_text.sv
// ---------------------------------------------------------------------------
// matrix_text
// Inverse of the text/key matrix loader. Captures a finished 4x4 nibble state
// matrix, flattens it into the 16-nibble text vector and streams the nibbles
// out one per handshake.
// Ports:
//   clck : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : matrix_text_if.slave (matrix handshake, text, nibble stream,
//          text_done)
// Parameters:
//   NIBBLE_W  : cell width
//   MSB_FIRST : 1 streams text[15] first, 0 streams text[0] first
// ---------------------------------------------------------------------------
module matrix_text
  import cipher_pkg::*;
#(
  parameter int NIBBLE_W  = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clck,
  input  logic         rst,
  matrix_text_if.slave bus
);

  mt_state_e                      state_p0;
  mt_state_e                      state_d;
  logic [3:0]                     cnt_p0;
  logic [CELLS-1:0][NIBBLE_W-1:0] text_p0;
  logic [CELLS-1:0][NIBBLE_W-1:0] text_map;
  logic                           done_p0;

  logic                           in_ready_c;
  logic                           nib_valid_c;
  logic                           take_in;
  logic                           take_nib;
  logic                           last_nib;
  logic [3:0]                     sel;
  logic [NIBBLE_W-1:0]            nib_sel;

  // Matrix -> text flattening, same ordering as the loader.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    for (genvar gj = 0; gj < 4; gj++) begin : g_col
      assign text_map[cell_idx(gi, gj)] = bus.st_matrix[gi][gj];
    end
  end

  assign take_in  = bus.in_valid && in_ready_c;
  assign take_nib = nib_valid_c && bus.nib_ready;
  assign last_nib = (cnt_p0 == 4'd15);

  // ---- stage p0: state register ----
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
    end else begin
      state_p0 <= state_d;
    end
  end

  always_comb begin
    state_d = state_p0;
    case (state_p0)
      ST_IDLE: if (take_in)             state_d = ST_SEND;
      ST_SEND: if (take_nib && last_nib) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    in_ready_c  = (state_p0 == ST_IDLE);
    nib_valid_c = (state_p0 == ST_SEND);
  end

  // ---- stage p0: text, nibble counter, completion pulse ----
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      text_p0 <= '0;
      cnt_p0  <= '0;
      done_p0 <= 1'b0;
    end else begin
      done_p0 <= take_nib && last_nib;
      if (take_in) begin
        text_p0 <= text_map;
        cnt_p0  <= '0;
      end else if (take_nib) begin
        // Wraps to 0 after the 16th nibble; the wrapped value is never used.
        cnt_p0 <= cnt_p0 + 4'd1;
      end
    end
  end

  // Output nibble is a pure mux of registered text by registered counter.
  always_comb begin
    sel     = MSB_FIRST ? (4'd15 - cnt_p0) : cnt_p0;
    nib_sel = text_p0[sel];
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.nib_valid = nib_valid_c;
  assign bus.nib_out   = nib_sel;
  assign bus.text      = text_p0;
  assign bus.text_done = done_p0;

endmodule

// File: tb/tb_matrix_text.sv
// ---------------------------------------------------------------------------
// tb_matrix_text
// Directed bench for matrix_text: one MSB-first and one LSB-first instance
// sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_matrix_text;
  import cipher_pkg::*;

  logic clck = 1'b0;
  logic rst;
  always #5 clck = ~clck;

  matrix_text_if ia ();
  matrix_text_if ib ();

  matrix_text #(.NIBBLE_W(4), .MSB_FIRST(1'b1)) dut_msb (
    .clck (clck),
    .rst  (rst),
    .bus  (ia)
  );

  matrix_text #(.NIBBLE_W(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clck (clck),
    .rst  (rst),
    .bus  (ib)
  );

  int checks = 0;
  int errors = 0;

  function automatic state_mat_t ramp_mat();
    state_mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = nibble_t'(4 * i + j);
    return m;
  endfunction

  function automatic state_mat_t fill_mat(input nibble_t v);
    state_mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = v;
    return m;
  endfunction

  // For the ramp matrix text[k] = 15-k (text[15]=0 ... text[0]=F).
  function automatic text_vec_t ramp_text();
    text_vec_t t;
    for (int k = 0; k < 16; k++) t[k] = nibble_t'(15 - k);
    return t;
  endfunction

  task automatic tick();
    @(posedge clck);
    #1;
  endtask

  task automatic wait_ready_a(input string tag);
    int n = 0;
    while (ia.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ia.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_wait got in_ready=%b want 1", tag, ia.in_ready);
    end
  endtask

  // Presents m with in_valid; returns one tick after the capture edge (E0+1).
  task automatic capture_a(input state_mat_t m, input bit hold);
    ia.st_matrix = m;
    ia.in_valid  = 1'b1;
    tick();
    if (!hold) ia.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.nib_ready = 1'b1; ia.st_matrix = '0;
    ib.in_valid = 1'b0; ib.nib_ready = 1'b1; ib.st_matrix = '0;
    tick(); tick();
    checks++;
    if (ia.in_ready !== 1'b1 || ib.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got %b/%b want 1/1", ia.in_ready, ib.in_ready);
    end
    checks++;
    if (ia.nib_valid !== 1'b0 || ia.text_done !== 1'b0 || ia.nib_out !== 4'h0) begin
      errors++;
      $display("FAIL rst_outputs got vld=%b done=%b nib=%h want 0/0/0",
               ia.nib_valid, ia.text_done, ia.nib_out);
    end
    checks++;
    if (ia.text !== '0 || ib.text !== '0) begin
      errors++;
      $display("FAIL rst_text got %h/%h want 0", ia.text, ib.text);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ia.in_ready !== 1'b1 || ia.nib_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got rdy=%b vld=%b want 1/0", ia.in_ready, ia.nib_valid);
    end
  endtask

  task automatic test_basic();
    text_vec_t exp_t = ramp_text();
    wait_ready_a("basic");
    capture_a(ramp_mat(), 1'b0);
    checks++;
    if (ia.text !== exp_t) begin
      errors++;
      $display("FAIL basic_text got %h want %h", ia.text, exp_t);
    end
    checks++;
    if (ia.nib_valid !== 1'b1 || ia.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_send_flags got vld=%b rdy=%b want 1/0", ia.nib_valid, ia.in_ready);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ia.nib_out !== nibble_t'(k) || ia.text_done !== 1'b0) begin
        errors++;
        $display("FAIL basic_nib%0d got %h done=%b want %h done=0",
                 k, ia.nib_out, ia.text_done, nibble_t'(k));
      end
      tick();
    end
    checks++;
    if (ia.text_done !== 1'b1 || ia.in_ready !== 1'b1 || ia.nib_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b rdy=%b vld=%b want 1/1/0",
               ia.text_done, ia.in_ready, ia.nib_valid);
    end
    tick();
    checks++;
    if (ia.text_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got %b want 0", ia.text_done);
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    wait_ready_a("bp");
    capture_a(ramp_mat(), 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        ia.nib_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
          checks++;
          if (ia.nib_out !== 4'h5 || ia.nib_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d got %h vld=%b want 5 vld=1", r, ia.nib_out, ia.nib_valid);
          end
          tick();
          cyc++;
        end
        ia.nib_ready = 1'b1;
      end
      checks++;
      if (ia.nib_out !== nibble_t'(k)) begin
        errors++;
        $display("FAIL bp_nib%0d got %h want %h", k, ia.nib_out, nibble_t'(k));
      end
      tick();
      cyc++;
    end
    checks++;
    if (ia.text_done !== 1'b1 || cyc != 19) begin
      errors++;
      $display("FAIL bp_done got done=%b after %0d edges want 1 after 19", ia.text_done, cyc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    text_vec_t exp_t = ramp_text();
    wait_ready_a("b2b");
    capture_a(ramp_mat(), 1'b1);
    // New matrix presented with in_valid still high while the first streams.
    ia.st_matrix = fill_mat(4'hA);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ia.nib_out !== nibble_t'(k) || ia.text !== exp_t) begin
        errors++;
        $display("FAIL b2b_first%0d got %h text=%h want %h text=%h",
                 k, ia.nib_out, ia.text, nibble_t'(k), exp_t);
      end
      tick();
    end
    checks++;
    if (ia.text_done !== 1'b1 || ia.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1 got done=%b rdy=%b want 1/1", ia.text_done, ia.in_ready);
    end
    tick();
    ia.in_valid = 1'b0;
    checks++;
    if (ia.text !== {16{4'hA}} || ia.nib_valid !== 1'b1 || ia.text_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_capture got text=%h vld=%b done=%b want all-A/1/0",
               ia.text, ia.nib_valid, ia.text_done);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ia.nib_out !== 4'hA) begin
        errors++;
        $display("FAIL b2b_second%0d got %h want a", k, ia.nib_out);
      end
      tick();
    end
    checks++;
    if (ia.text_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done2 got %b want 1", ia.text_done);
    end
    tick();
  endtask

  task automatic test_lsb_first();
    text_vec_t exp_t = ramp_text();
    ib.st_matrix = ramp_mat();
    ib.in_valid  = 1'b1;
    tick();
    ib.in_valid  = 1'b0;
    checks++;
    if (ib.text !== exp_t) begin
      errors++;
      $display("FAIL lsb_text got %h want %h", ib.text, exp_t);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ib.nib_out !== nibble_t'(15 - k)) begin
        errors++;
        $display("FAIL lsb_nib%0d got %h want %h", k, ib.nib_out, nibble_t'(15 - k));
      end
      tick();
    end
    checks++;
    if (ib.text_done !== 1'b1) begin
      errors++;
      $display("FAIL lsb_done got %b want 1", ib.text_done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    state_mat_t m2;
    bit done_seen = 1'b0;
    wait_ready_a("rmid");
    capture_a(ramp_mat(), 1'b0);
    repeat (9) tick();
    checks++;
    if (ia.nib_out !== 4'h9) begin
      errors++;
      $display("FAIL rmid_pre got %h want 9", ia.nib_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ia.nib_out !== 4'h0 || ia.nib_valid !== 1'b0 || ia.in_ready !== 1'b1 ||
        ia.text !== '0 || ia.text_done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async got nib=%h vld=%b rdy=%b text=%h done=%b want 0/0/1/0/0",
               ia.nib_out, ia.nib_valid, ia.in_ready, ia.text, ia.text_done);
    end
    @(negedge clck);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ia.text_done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin
      errors++;
      $display("FAIL rmid_no_done got %b want 0", done_seen);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m2[i][j] = nibble_t'(15 - (4 * i + j));
    wait_ready_a("rmid2");
    capture_a(m2, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ia.nib_out !== nibble_t'(15 - k)) begin
        errors++;
        $display("FAIL rmid_new%0d got %h want %h", k, ia.nib_out, nibble_t'(15 - k));
      end
      tick();
    end
    checks++;
    if (ia.text_done !== 1'b1) begin
      errors++;
      $display("FAIL rmid_new_done got %b want 1", ia.text_done);
    end
    tick();
  endtask

  task automatic test_round_trip();
    state_mat_t m;
    state_mat_t lm;
    text_vec_t  t;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          m[i][j] = nibble_t'($urandom_range(0, 15));
      wait_ready_a("rt");
      capture_a(m, 1'b0);
      t = ia.text;
      // Loader model: st_matrix[i][j] = text[15-(4i+j)].
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          lm[i][j] = t[15 - (4 * i + j)];
      checks++;
      if (lm !== m) begin
        errors++;
        $display("FAIL rt%0d got %h want %h", n, lm, m);
      end
      repeat (16) tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
